// File: rtl/enigma_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : enigma_tx_sched                                               |
// | Purpose  : Shares one tx_serial transmitter between the prompt (src0),   |
// |            echo (src1) and cipher (src2) byte sources. src0/src1 each    |
// |            have a one-byte holding register; src2 has a DEPTH-entry FIFO.|
// |            Fixed priority src0 > src1 > src2, arbitrated in IDLE only.   |
// | Option   : `define TXSCHED_GROUP5_EN inserts a space (0x20) after every  |
// |            five cipher bytes; a granted prompt byte restarts the group.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module enigma_tx_sched #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int START_TMO = 7
) (
  input  logic          clk100,
  input  logic          reset_n,
  input  logic [7:0]    prm_byte,
  input  logic          prm_wr,
  input  logic [7:0]    ech_byte,
  input  logic          ech_wr,
  input  logic [7:0]    cph_byte,
  input  logic          cph_wr,
  input  logic          ovf_clr,
  output logic [7:0]    sbyte,
  output logic          send,
  input  logic          tx_busy,
  output logic          pending,
  output logic [2:0]    ovf,
  output logic [AW:0]   cph_level
);

  // Timeout counter only has to count 0 .. START_TMO-1.
  localparam int            TW       = (START_TMO > 1) ? $clog2(START_TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);
  localparam logic [7:0]    SPACE    = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_START = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    sbyte_q;
  logic          send_q;
  logic [TW-1:0] tmo_q;

  logic          prm_vld_q, prm_vld_d;
  logic [7:0]    prm_q, prm_d;
  logic          ech_vld_q, ech_vld_d;
  logic [7:0]    ech_q, ech_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [2:0]    ovf_q, ovf_d;

  logic          cph_empty, cph_full;
  logic          prm_acc, ech_acc, cph_push;
  logic          grant, pop_prm, pop_ech, pop_cph;
  logic [7:0]    grant_byte;

`ifdef TXSCHED_GROUP5_EN
  logic [2:0]    grp_q, grp_d;
`endif

  assign cph_empty = (wptr_q == rptr_q);
  assign cph_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Fixed-priority arbiter; only grants while the FSM sits in IDLE.
  always_comb begin
    grant      = 1'b0;
    pop_prm    = 1'b0;
    pop_ech    = 1'b0;
    pop_cph    = 1'b0;
    grant_byte = 8'h00;
`ifdef TXSCHED_GROUP5_EN
    grp_d      = grp_q;
`endif
    if (state_q == S_IDLE) begin
      if (prm_vld_q) begin
        grant      = 1'b1;
        pop_prm    = 1'b1;
        grant_byte = prm_q;
`ifdef TXSCHED_GROUP5_EN
        grp_d      = 3'd0;
`endif
      end else if (ech_vld_q) begin
        grant      = 1'b1;
        pop_ech    = 1'b1;
        grant_byte = ech_q;
      end else if (!cph_empty) begin
        grant      = 1'b1;
`ifdef TXSCHED_GROUP5_EN
        // Sixth cipher slot becomes a space; the cipher byte stays queued.
        if (grp_q == 3'd5) begin
          grant_byte = SPACE;
          grp_d      = 3'd0;
        end else begin
          grant_byte = mem_q[rptr_q[AW-1:0]];
          pop_cph    = 1'b1;
          grp_d      = grp_q + 3'd1;
        end
`else
        grant_byte = mem_q[rptr_q[AW-1:0]];
        pop_cph    = 1'b1;
`endif
      end
    end
  end

  // Write acceptance: a full slot still accepts when it is popped this cycle.
  always_comb begin
    prm_acc   = prm_wr & (~prm_vld_q | pop_prm);
    ech_acc   = ech_wr & (~ech_vld_q | pop_ech);
    cph_push  = cph_wr & (~cph_full | pop_cph);
    prm_vld_d = prm_acc | (prm_vld_q & ~pop_prm);
    ech_vld_d = ech_acc | (ech_vld_q & ~pop_ech);
    prm_d     = prm_acc ? prm_byte : prm_q;
    ech_d     = ech_acc ? ech_byte : ech_q;
    wptr_d    = wptr_q + {{AW{1'b0}}, cph_push};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop_cph};
    // Clear wins over any overflow raised in the same cycle.
    if (ovf_clr) ovf_d = 3'b000;
    else         ovf_d = ovf_q | {cph_wr & ~cph_push, ech_wr & ~ech_acc, prm_wr & ~prm_acc};
  end

  // Source storage state: holding registers, FIFO pointers, overflow flags.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      prm_vld_q <= 1'b0;
      prm_q     <= 8'h00;
      ech_vld_q <= 1'b0;
      ech_q     <= 8'h00;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 3'b000;
    end else begin
      prm_vld_q <= prm_vld_d;
      prm_q     <= prm_d;
      ech_vld_q <= ech_vld_d;
      ech_q     <= ech_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Cipher FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk100) begin
    if (cph_push) mem_q[wptr_q[AW-1:0]] <= cph_byte;
  end

`ifdef TXSCHED_GROUP5_EN
  // Cipher group counter for the space-insertion option.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) grp_q <= 3'd0;
    else          grp_q <= grp_d;
  end
`endif

  // Transmit handshake FSM with registered sbyte/send.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sbyte_q <= 8'h00;
      send_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      send_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            sbyte_q <= grant_byte;
            send_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT_START;
        end
        S_WAIT_START: begin
          // Give up on a busy that never arrives so the queue keeps draining.
          if (tx_busy)                state_q <= S_WAIT_DONE;
          else if (tmo_q == TMO_LAST) state_q <= S_IDLE;
          else                        tmo_q   <= tmo_q + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sbyte     = sbyte_q;
  assign send      = send_q;
  assign ovf       = ovf_q;
  assign cph_level = wptr_q - rptr_q;
  assign pending   = prm_vld_q | ech_vld_q | ~cph_empty | (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_enigma_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_enigma_tx_sched                                            |
// | Purpose  : Directed and randomized checks of enigma_tx_sched against a   |
// |            transaction-level model of the three byte sources.            |
// | Option   : TXSCHED_GROUP5_EN selects the space-insertion scenario.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_enigma_tx_sched;
  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int START_TMO = 7;

  logic          clk100   = 1'b0;
  logic          reset_n  = 1'b0;
  logic [7:0]    prm_byte = 8'h00;
  logic          prm_wr   = 1'b0;
  logic [7:0]    ech_byte = 8'h00;
  logic          ech_wr   = 1'b0;
  logic [7:0]    cph_byte = 8'h00;
  logic          cph_wr   = 1'b0;
  logic          ovf_clr  = 1'b0;
  logic          tx_busy  = 1'b0;
  logic [7:0]    sbyte;
  logic          send;
  logic          pending;
  logic [2:0]    ovf;
  logic [AW:0]   cph_level;

  enigma_tx_sched #(.DEPTH(DEPTH), .AW(AW), .START_TMO(START_TMO)) dut (
    .clk100(clk100), .reset_n(reset_n),
    .prm_byte(prm_byte), .prm_wr(prm_wr),
    .ech_byte(ech_byte), .ech_wr(ech_wr),
    .cph_byte(cph_byte), .cph_wr(cph_wr),
    .ovf_clr(ovf_clr), .sbyte(sbyte), .send(send), .tx_busy(tx_busy),
    .pending(pending), .ovf(ovf), .cph_level(cph_level)
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc++;

  // Every send pulse, with the byte on sbyte and the cycle it occurred in.
  logic [7:0] mon_b[$];
  int         mon_c[$];
  always @(negedge clk100) begin
    if (reset_n && send === 1'b1) begin
      mon_b.push_back(sbyte);
      mon_c.push_back(cyc);
    end
  end

  // tx_serial stand-in: mode 0 = busy for busy_len cycles starting one cycle
  // after send, 1 = busy stuck high, 2 = busy never rises.
  int busy_mode = 0;
  int busy_len  = 10;
  int bcnt      = 0;
  bit dly       = 1'b0;
  always @(posedge clk100) begin
    #1;
    if (!reset_n) begin
      tx_busy = 1'b0; bcnt = 0; dly = 1'b0;
    end else if (busy_mode == 1) begin
      tx_busy = 1'b1; bcnt = 0; dly = 1'b0;
    end else if (busy_mode == 2) begin
      tx_busy = 1'b0; bcnt = 0; dly = 1'b0;
    end else begin
      if (dly) begin
        dly = 1'b0; tx_busy = 1'b1; bcnt = busy_len - 1;
      end else if (tx_busy) begin
        if (bcnt == 0) tx_busy = 1'b0;
        else           bcnt--;
      end
      if (send === 1'b1) dly = 1'b1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic pulse_prm(input logic [7:0] b);
    prm_byte = b; prm_wr = 1'b1; step(); prm_wr = 1'b0;
  endtask

  task automatic pulse_ech(input logic [7:0] b);
    ech_byte = b; ech_wr = 1'b1; step(); ech_wr = 1'b0;
  endtask

  task automatic pulse_cph(input logic [7:0] b);
    cph_byte = b; cph_wr = 1'b1; step(); cph_wr = 1'b0;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
  endtask

  task automatic wait_sends(input string tag, input int n, input int bound);
    int k = 0;
    while (mon_b.size() < n && k < bound) begin step(); k++; end
    check(tag, mon_b.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (pending !== 1'b0 && k < bound) begin step(); k++; end
    check(tag, {31'd0, pending}, 32'd0);
  endtask

  task automatic expect_send(input string tag, input logic [7:0] exp);
    logic [7:0] b = 8'hxx;
    if (mon_b.size() > 0) begin
      b = mon_b.pop_front();
      void'(mon_c.pop_front());
    end
    check(tag, {24'd0, b}, {24'd0, exp});
  endtask

  // Reference model of the source queues: byte plus cycle of its write.
  logic [7:0] q0b[$], q1b[$], q2b[$];
  int         q0c[$], q1c[$], q2c[$];

  // A byte granted at the edge opening send cycle s was visible in cycle s-1,
  // i.e. it was written in cycle s-2 or earlier; the highest-priority such
  // source must be the one that was sent.
  task automatic process_sends();
    logic [7:0] b;
    int         s;
    logic [31:0] exp;
    while (mon_b.size() > 0) begin
      b = mon_b.pop_front();
      s = mon_c.pop_front();
      exp = 32'hFFFF_FFFF;
      if (q0c.size() > 0 && q0c[0] <= s - 2) begin
        exp = {24'd0, q0b.pop_front()}; void'(q0c.pop_front());
      end else if (q1c.size() > 0 && q1c[0] <= s - 2) begin
        exp = {24'd0, q1b.pop_front()}; void'(q1c.pop_front());
      end else if (q2c.size() > 0 && q2c[0] <= s - 2) begin
        exp = {24'd0, q2b.pop_front()}; void'(q2c.pop_front());
      end
      check("rnd_send_byte", {24'd0, b}, exp);
    end
  endtask

  initial begin
    int         wc;
    int         c0;
    logic [7:0] rb;
`ifdef TXSCHED_GROUP5_EN
    string      exp_s;
`endif

    // Reset state
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_sbyte", {24'd0, sbyte}, 32'h00);
    check("rst_send", {31'd0, send}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_ovf", {29'd0, ovf}, 32'd0);
    check("rst_level", {28'd0, cph_level}, 32'd0);
    reset_n = 1'b1;
    step();

    // Single byte, latency from write cycle to send cycle
    busy_mode = 0; busy_len = 10;
    mon_b.delete(); mon_c.delete();
    wc = cyc;
    pulse_prm(8'h3E);
    wait_sends("single_cnt", 1, 20);
    c0 = (mon_c.size() > 0) ? mon_c[0] : -100;
    check("single_latency", c0 - wc, 2);
    expect_send("single_byte", 8'h3E);
    wait_idle("single_idle", 40);
    check("single_no_extra", mon_b.size(), 0);

    // Same-cycle writes from all three sources
    prm_byte = 8'h3E; ech_byte = 8'h41; cph_byte = 8'h58;
    prm_wr = 1'b1; ech_wr = 1'b1; cph_wr = 1'b1;
    step();
    prm_wr = 1'b0; ech_wr = 1'b0; cph_wr = 1'b0;
    wait_sends("prio_cnt", 3, 100);
    expect_send("prio_0", 8'h3E);
    expect_send("prio_1", 8'h41);
    expect_send("prio_2", 8'h58);
    check("prio_ovf", {29'd0, ovf}, 32'd0);
    wait_idle("prio_idle", 40);

    // Cipher FIFO overflow with the transmitter held busy
    busy_mode = 1;
    pulse_prm(8'h3E);
    wait_sends("fifo_prm_cnt", 1, 20);
    expect_send("fifo_prm", 8'h3E);
    for (int i = 0; i < 9; i++) begin
      cph_byte = 8'(8'h41 + i); cph_wr = 1'b1; step();
    end
    cph_wr = 1'b0;
    step();
    check("fifo_level_full", {28'd0, cph_level}, 32'd8);
    check("fifo_ovf", {29'd0, ovf}, 32'h4);
    busy_mode = 0; busy_len = 3;
    wait_sends("fifo_drain_cnt", 8, 300);
    for (int i = 0; i < 8; i++) expect_send("fifo_order", 8'(8'h41 + i));
    wait_idle("fifo_idle", 40);
    check("fifo_no_extra", mon_b.size(), 0);
    check("fifo_ovf_sticky", {29'd0, ovf}, 32'h4);
    pulse_clr();
    check("fifo_ovf_clr", {29'd0, ovf}, 32'd0);

    // Holding register overflow while in WAIT_DONE
    busy_mode = 1;
    pulse_prm(8'h3E);
    wait_sends("hold_prm_cnt", 1, 20);
    expect_send("hold_prm", 8'h3E);
    pulse_ech(8'h42);
    pulse_ech(8'h43);
    check("hold_ovf", {29'd0, ovf}, 32'h2);
    busy_mode = 0;
    wait_sends("hold_cnt", 1, 50);
    expect_send("hold_byte", 8'h42);
    wait_idle("hold_idle", 40);
    check("hold_dropped", mon_b.size(), 0);
    pulse_clr();
    check("hold_ovf_clr", {29'd0, ovf}, 32'd0);

    // Echo write landing on the same edge as the echo grant
    ech_byte = 8'h44; ech_wr = 1'b1; step();
    ech_byte = 8'h45; step();
    ech_wr = 1'b0;
    wait_sends("grant_wr_cnt", 2, 100);
    expect_send("grant_wr_0", 8'h44);
    expect_send("grant_wr_1", 8'h45);
    check("grant_wr_ovf", {29'd0, ovf}, 32'd0);
    wait_idle("grant_wr_idle", 40);

    // Start timeout: busy never rises
    busy_mode = 2;
    prm_byte = 8'h50; ech_byte = 8'h51; prm_wr = 1'b1; ech_wr = 1'b1;
    step();
    prm_wr = 1'b0; ech_wr = 1'b0;
    wait_sends("tmo_cnt", 2, 100);
    c0 = (mon_c.size() > 1) ? (mon_c[1] - mon_c[0]) : -1;
    check("tmo_spacing", c0, START_TMO + 2);
    expect_send("tmo_0", 8'h50);
    expect_send("tmo_1", 8'h51);
    wait_idle("tmo_idle", 40);
    busy_mode = 0;

`ifdef TXSCHED_GROUP5_EN
    // Space insertion every five cipher bytes; prompt restarts the group
    busy_len = 2;
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 4; j++) pulse_cph(8'(8'h41 + 4 * g + j));
      wait_idle("grp_batch_idle", 200);
    end
    pulse_prm(8'h3E);
    wait_idle("grp_prm_idle", 100);
    for (int j = 0; j < 3; j++) pulse_cph(8'(8'h4D + j));
    wait_idle("grp_tail_idle", 100);
    exp_s = "ABCDE FGHIJ KL>MNO";
    check("grp_cnt", mon_b.size(), exp_s.len());
    for (int j = 0; j < exp_s.len(); j++) expect_send("grp_char", exp_s[j]);
`else
    // Randomized traffic checked against the source-queue model
    for (int i = 0; i < 400; i++) begin
      prm_wr = 1'b0; ech_wr = 1'b0; cph_wr = 1'b0;
      process_sends();
      busy_len = $urandom_range(1, 6);
      if (q0b.size() == 0 && $urandom_range(0, 9) == 0) begin
        rb = 8'($urandom); prm_byte = rb; prm_wr = 1'b1;
        q0b.push_back(rb); q0c.push_back(cyc);
      end
      if (q1b.size() == 0 && $urandom_range(0, 7) == 0) begin
        rb = 8'($urandom); ech_byte = rb; ech_wr = 1'b1;
        q1b.push_back(rb); q1c.push_back(cyc);
      end
      if (q2b.size() < DEPTH && $urandom_range(0, 2) == 0) begin
        rb = 8'($urandom); cph_byte = rb; cph_wr = 1'b1;
        q2b.push_back(rb); q2c.push_back(cyc);
      end
      step();
    end
    prm_wr = 1'b0; ech_wr = 1'b0; cph_wr = 1'b0;
    for (int k = 0; k < 1000 && (pending !== 1'b0 || mon_b.size() > 0); k++) begin
      process_sends();
      step();
    end
    step();
    process_sends();
    check("rnd_q_empty", q0b.size() + q1b.size() + q2b.size(), 0);
    check("rnd_ovf", {29'd0, ovf}, 32'd0);
    check("rnd_level", {28'd0, cph_level}, 32'd0);
    check("rnd_pending", {31'd0, pending}, 32'd0);
`endif

    // Reset in the middle of a transfer drops everything
    busy_mode = 1;
    pulse_cph(8'h61);
    pulse_cph(8'h62);
    step();
    reset_n = 1'b0;
    #1;
    check("midrst_sbyte", {24'd0, sbyte}, 32'h00);
    check("midrst_pending", {31'd0, pending}, 32'd0);
    check("midrst_level", {28'd0, cph_level}, 32'd0);
    step();
    reset_n = 1'b1;
    busy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
